dpram_sync_tdp: RTL and testbench

- Single-clock true dual-port RAM. It generalises the team's fixed 16x32 two-clock dual-port buffer to any data width and depth.
- Adds byte-lane writes on both ports, deterministic collision resolution, read-valid tracking and a hardware clear sequence after reset.
- Used as the parametrised burst/line buffer between the Wishbone side and the SDRAM controller core when both run on one clock.

---
 rtl/dpram_sync_tdp_if.sv | 18 +
 rtl/dpram_sync_tdp.sv | 166 ++++++++++++++++
 tb/tb_dpram_sync_tdp.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_sync_tdp_if.sv
// One port of the dual-port RAM: access request, byte-lane write data and registered read return.
// Zero latency (plain wires); no backpressure, the RAM side reports acceptance through valid.
interface dpram_sync_tdp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic                  en;
    logic [BYTES-1:0]      we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;

    modport master (output en, we, addr, din, input dout, valid);
    modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/dpram_sync_tdp.sv
// Single-clock true dual-port RAM with byte lanes, write-first bypass and a post-reset clear; read latency 1,
// or 2 when built with DPRAM_SYNC_TDP_OUTREG_EN. No backpressure: both ports are ignored while busy is high.
module dpram_sync_tdp #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   busy,
    output logic                   collision,
    dpram_sync_tdp_if.slave        a,
    dpram_sync_tdp_if.slave        b
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [BYTES-1:0]      lane_t;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t state, state_nxt;
    addr_t  clr_cnt, clr_cnt_nxt;
    logic   clr_wr;

    word_t  mem [DEPTH];

    logic   acc_a, acc_b, same_addr, coll_nxt;
    lane_t  a_wr, b_wr;
    word_t  a_rd, b_rd;

    word_t  a_dout_q, b_dout_q;
    logic   a_valid_q, b_valid_q, coll_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_wr      = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_CLEAR: begin
                clr_wr      = 1'b1;
                clr_cnt_nxt = clr_cnt + addr_t'(1);
                if (clr_cnt == addr_t'(DEPTH - 1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                busy = 1'b0;
            end
        endcase
    end

    assign acc_a     = a.en && !busy && !rst;
    assign acc_b     = b.en && !busy && !rst;
    assign a_wr      = {BYTES{acc_a}} & a.we;
    assign b_wr      = {BYTES{acc_b}} & b.we;
    assign same_addr = (a.addr == b.addr);
    assign coll_nxt  = acc_a && acc_b && same_addr && (|(a.we & b.we));

    // Port B lanes are written first so port A wins any lane both ports enable.
    always_ff @(posedge clk) begin
        if (clr_wr && !rst) begin
            mem[clr_cnt] <= CLEAR_VALUE;
        end
        for (int i = 0; i < BYTES; i++) begin
            if (b_wr[i]) begin
                mem[b.addr][8*i +: 8] <= b.din[8*i +: 8];
            end
            if (a_wr[i]) begin
                mem[a.addr][8*i +: 8] <= a.din[8*i +: 8];
            end
        end
    end

    // Read path returns the word as it will be stored after this edge, with the same A-over-B lane priority.
    always_comb begin
        a_rd = mem[a.addr];
        b_rd = mem[b.addr];
        for (int i = 0; i < BYTES; i++) begin
            if (same_addr && b_wr[i]) begin
                a_rd[8*i +: 8] = b.din[8*i +: 8];
            end
            if (a_wr[i]) begin
                a_rd[8*i +: 8] = a.din[8*i +: 8];
            end
            if (b_wr[i]) begin
                b_rd[8*i +: 8] = b.din[8*i +: 8];
            end
            if (same_addr && a_wr[i]) begin
                b_rd[8*i +: 8] = a.din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout_q  <= '0;
            b_dout_q  <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            a_valid_q <= acc_a;
            b_valid_q <= acc_b;
            coll_q    <= coll_nxt;
            if (acc_a) begin
                a_dout_q <= a_rd;
            end
            if (acc_b) begin
                b_dout_q <= b_rd;
            end
        end
    end

`ifdef DPRAM_SYNC_TDP_OUTREG_EN
    word_t a_dout_q2, b_dout_q2;
    logic  a_valid_q2, b_valid_q2, coll_q2;

    // Second stage only reloads on a valid first-stage result so dout keeps holding between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_dout_q2  <= '0;
            b_dout_q2  <= '0;
            a_valid_q2 <= 1'b0;
            b_valid_q2 <= 1'b0;
            coll_q2    <= 1'b0;
        end else begin
            a_valid_q2 <= a_valid_q;
            b_valid_q2 <= b_valid_q;
            coll_q2    <= coll_q;
            if (a_valid_q) begin
                a_dout_q2 <= a_dout_q;
            end
            if (b_valid_q) begin
                b_dout_q2 <= b_dout_q;
            end
        end
    end

    assign a.dout    = a_dout_q2;
    assign a.valid   = a_valid_q2;
    assign b.dout    = b_dout_q2;
    assign b.valid   = b_valid_q2;
    assign collision = coll_q2;
`else
    assign a.dout    = a_dout_q;
    assign a.valid   = a_valid_q;
    assign b.dout    = b_dout_q;
    assign b.valid   = b_valid_q;
    assign collision = coll_q;
`endif

endmodule

// File: tb/tb_dpram_sync_tdp.sv
// Directed bench for dpram_sync_tdp: a reference memory model predicts every cycle's outputs into a queue.
module tb_dpram_sync_tdp;
    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CLR   = 32'hDEADBEEF;
`ifdef DPRAM_SYNC_TDP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic collision;

    dpram_sync_tdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
    dpram_sync_tdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

    dpram_sync_tdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(CLR)) dut (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .collision (collision),
        .a         (a_if),
        .b         (b_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        a_vld;
        logic [31:0] a_dat;
        logic        b_vld;
        logic [31:0] b_dat;
        logic        coll;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [DEPTH];
    logic        mdl_clear;
    logic [3:0]  mdl_cnt;
    logic [31:0] last_a, last_b;
    int          errors = 0;
    int          checks = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] din, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = din[8*i +: 8];
        end
        return r;
    endfunction

    task automatic drive(input logic ae, input logic [3:0] awe, input logic [3:0] aad, input logic [31:0] adi,
                         input logic be, input logic [3:0] bwe, input logic [3:0] bad, input logic [31:0] bdi);
        a_if.en = ae; a_if.we = awe; a_if.addr = aad; a_if.din = adi;
        b_if.en = be; b_if.we = bwe; b_if.addr = bad; b_if.din = bdi;
    endtask

    // One clock: predict, push, advance, then compare the entry whose latency has elapsed.
    task automatic step();
        exp_t        e;
        logic [3:0]  la, lb;
        logic        acc_a, acc_b, sa;
        logic [31:0] ra, rb;
        if (rst) begin
            mdl_clear = 1'b1;
            mdl_cnt   = '0;
            last_a    = '0;
            last_b    = '0;
            sb.delete();
            @(posedge clk); #1;
            chk1("rst_busy", busy, 1'b1);
            chk1("rst_a_valid", a_if.valid, 1'b0);
            chk1("rst_b_valid", b_if.valid, 1'b0);
            chk32("rst_a_dout", a_if.dout, 32'h0);
            chk32("rst_b_dout", b_if.dout, 32'h0);
            chk1("rst_collision", collision, 1'b0);
            return;
        end
        e     = '0;
        acc_a = a_if.en && !mdl_clear;
        acc_b = b_if.en && !mdl_clear;
        if (mdl_clear) begin
            mdl[mdl_cnt] = CLR;
            if (mdl_cnt == 4'(DEPTH - 1)) mdl_clear = 1'b0;
            mdl_cnt = mdl_cnt + 4'd1;
        end else begin
            la = acc_a ? a_if.we : 4'b0;
            lb = acc_b ? b_if.we : 4'b0;
            sa = (a_if.addr == b_if.addr);
            ra = lanes(lanes(mdl[a_if.addr], b_if.din, sa ? lb : 4'b0), a_if.din, la);
            rb = lanes(lanes(mdl[b_if.addr], b_if.din, lb), a_if.din, sa ? la : 4'b0);
            mdl[b_if.addr] = lanes(mdl[b_if.addr], b_if.din, lb);
            mdl[a_if.addr] = lanes(mdl[a_if.addr], a_if.din, la);
            e.coll = acc_a && acc_b && sa && (|(la & lb));
            if (acc_a) last_a = ra;
            if (acc_b) last_b = rb;
        end
        e.a_vld = acc_a;
        e.b_vld = acc_b;
        e.a_dat = last_a;
        e.b_dat = last_b;
        sb.push_back(e);
        @(posedge clk); #1;
        chk1("busy", busy, mdl_clear);
        if (sb.size() == LAT) begin
            e = sb.pop_front();
            chk1("a_valid", a_if.valid, e.a_vld);
            chk32("a_dout", a_if.dout, e.a_dat);
            chk1("b_valid", b_if.valid, e.b_vld);
            chk32("b_dout", b_if.dout, e.b_dat);
            chk1("collision", collision, e.coll);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        rst = 1'b1;
        drive(0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 32'h0);
        step();
        step();
        rst = 1'b0;

        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            step();
            bc++;
        end
        chk32("busy_cycles", bc, 32'd16);

        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 4'h0, 4'(i), 32'h0, 1, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
            step();
        end
        idle(LAT);
        chk32("clear_a_last", a_if.dout, CLR);

        drive(1, 4'hF, 4'd3, 32'h11223344, 0, 4'h0, 4'h0, 32'h0); step();
        drive(1, 4'h5, 4'd3, 32'hAABBCCDD, 0, 4'h0, 4'h0, 32'h0); step();
        drive(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 4'd3, 32'h0);        step();
        idle(LAT);
        chk32("lane_write", b_if.dout, 32'h11BB33DD);

        drive(1, 4'hF, 4'd5, 32'h12345678, 0, 4'h0, 4'h0, 32'h0); step();
        drive(1, 4'h3, 4'd5, 32'h0000CAFE, 1, 4'h0, 4'd5, 32'h0); step();
        idle(LAT - 1);
        chk1("bypass_valid", b_if.valid, 1'b1);
        chk32("bypass_dout", b_if.dout, 32'h1234CAFE);
        idle(1);
        chk1("bypass_valid_drop", b_if.valid, 1'b0);

        drive(0, 4'h0, 4'h0, 32'h0, 1, 4'hF, 4'd7, 32'hBBBBBBBB); step();
        drive(1, 4'hC, 4'd7, 32'hAAAAAAAA, 1, 4'h6, 4'd7, 32'hBBBBBBBB); step();
        idle(LAT - 1);
        chk1("coll_pulse", collision, 1'b1);
        idle(1);
        chk1("coll_drop", collision, 1'b0);
        drive(1, 4'h0, 4'd7, 32'h0, 1, 4'h0, 4'd7, 32'h0); step();
        idle(LAT);
        chk32("coll_word_a", a_if.dout, 32'hAAAABBBB);
        chk32("coll_word_b", b_if.dout, 32'hAAAABBBB);

        drive(1, 4'hF, 4'd1, 32'h01010101, 1, 4'hF, 4'd2, 32'h02020202); step();
        drive(1, 4'h0, 4'd2, 32'h0, 1, 4'h0, 4'd1, 32'h0);                step();
        drive(1, 4'h3, 4'd1, 32'h0000FFFF, 1, 4'hC, 4'd2, 32'hEEEE0000);  step();
        idle(2);

        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1, 4'hF, 4'd9, 32'h55555555, 1, 4'hF, 4'(i), 32'h66666666);
            step();
        end
        rst = 1'b1; step(); rst = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            drive(1, 4'hF, 4'd9, 32'h55555555, 1, 4'h0, 4'd9, 32'h0);
            step();
            bc++;
        end
        chk32("busy_cycles_restart", bc, 32'd16);

        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 4'h0, 4'(i), 32'h0, 1, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
            step();
        end
        idle(LAT);
        chk32("restart_a_last", a_if.dout, CLR);
        chk32("restart_b_last", b_if.dout, CLR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
